// File: rtl/traffic_phase_scheduler.sv
// Two-direction intersection sequencer: G1 -> Y1 -> R1 -> G2 -> Y2 -> R2 -> G1.
// A request for the red direction can shorten a green once its minimum time has
// elapsed. Night mode flashes yellow on both directions. All phase timing is
// derived from a 1 s tick prescaler that restarts on every state change.
//
// Lamp encoding is {red,yellow,green}, active-low (0 = lamp on).
// The current state is visible on 'phase' (IDLE=0 .. FLASH=7).
module traffic_phase_scheduler #(
  parameter int unsigned TICK_DIV    = 100_000_000,
  parameter int unsigned GREEN_S     = 20,
  parameter int unsigned YELLOW_S    = 3,
  parameter int unsigned ALLRED_S    = 1,
  parameter int unsigned MIN_GREEN_S = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req1,
  input  logic       req2,
  input  logic       night,
  output logic [2:0] lt1,
  output logic [2:0] lt2,
  output logic [2:0] phase,
  output logic [7:0] sec_left
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_G1    = 3'd1,
    S_Y1    = 3'd2,
    S_R1    = 3'd3,
    S_G2    = 3'd4,
    S_Y2    = 3'd5,
    S_R2    = 3'd6,
    S_FLASH = 3'd7
  } state_e;

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  // A green may end at a tick once the elapsed time after that tick reaches
  // MIN_GREEN_S, i.e. while sec_left (before the decrement) is at most this.
  localparam logic [7:0] EARLY_AT = 8'(GREEN_S - MIN_GREEN_S + 1);

  localparam logic [2:0] L_RED = 3'b011;
  localparam logic [2:0] L_YEL = 3'b101;
  localparam logic [2:0] L_GRN = 3'b110;
  localparam logic [2:0] L_OFF = 3'b111;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sec_q, sec_d;
  logic          flash_q, flash_d;
  logic          lat1_q, lat1_d;
  logic          lat2_q, lat2_d;
  logic [2:0]    lt1_q, lt1_d;
  logic [2:0]    lt2_q, lt2_d;

  logic tick;
  logic phase_end;
  logic trans;

  assign tick      = (cnt_q == CNT_MAX);
  assign phase_end = tick && (sec_q == 8'd1);
  assign trans     = (state_d != state_q);

  function automatic logic [7:0] phase_len(state_e s);
    case (s)
      S_G1, S_G2: phase_len = 8'(GREEN_S);
      S_Y1, S_Y2: phase_len = 8'(YELLOW_S);
      S_R1, S_R2: phase_len = 8'(ALLRED_S);
      default:    phase_len = 8'd0;
    endcase
  endfunction

  // State and all registered outputs; reset forces the IDLE lamp pattern at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sec_q   <= 8'd0;
      flash_q <= 1'b0;
      lat1_q  <= 1'b0;
      lat2_q  <= 1'b0;
      lt1_q   <= L_RED;
      lt2_q   <= L_RED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sec_q   <= sec_d;
      flash_q <= flash_d;
      lat1_q  <= lat1_d;
      lat2_q  <= lat2_d;
      lt1_q   <= lt1_d;
      lt2_q   <= lt2_d;
    end
  end

  // Next state: timed phases end on the tick where sec_left is 1; night is only
  // consulted at the end of an all-red and continuously while flashing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_R2;
      S_G1:    if (phase_end || (tick && lat2_q && (sec_q <= EARLY_AT))) state_d = S_Y1;
      S_Y1:    if (phase_end) state_d = S_R1;
      S_R1:    if (phase_end) state_d = night ? S_FLASH : S_G2;
      S_G2:    if (phase_end || (tick && lat1_q && (sec_q <= EARLY_AT))) state_d = S_Y2;
      S_Y2:    if (phase_end) state_d = S_R2;
      S_R2:    if (phase_end) state_d = night ? S_FLASH : S_G1;
      S_FLASH: if (!night) state_d = S_R2;
      default: state_d = S_IDLE;
    endcase
  end

  // Prescaler, phase timer, flash toggle and request latches.
  always_comb begin
    cnt_d   = (trans || tick) ? '0 : cnt_q + 1'b1;
    sec_d   = sec_q;
    flash_d = flash_q;
    if (trans) begin
      sec_d   = phase_len(state_d);
      flash_d = 1'b0;
    end else if (tick) begin
      if (sec_q != 8'd0) sec_d = sec_q - 8'd1;
      if (state_q == S_FLASH) flash_d = ~flash_q;
    end
    // Clearing on green entry wins over a same-cycle request; a request for
    // the direction already green is dropped.
    lat1_d = lat1_q;
    if (trans && (state_d == S_G1))      lat1_d = 1'b0;
    else if (req1 && (state_q != S_G1))  lat1_d = 1'b1;
    lat2_d = lat2_q;
    if (trans && (state_d == S_G2))      lat2_d = 1'b0;
    else if (req2 && (state_q != S_G2))  lat2_d = 1'b1;
  end

  // Lamp decode from the next state so lamps change in the same cycle as phase.
  always_comb begin
    lt1_d = L_RED;
    lt2_d = L_RED;
    case (state_d)
      S_G1:    lt1_d = L_GRN;
      S_Y1:    lt1_d = L_YEL;
      S_G2:    lt2_d = L_GRN;
      S_Y2:    lt2_d = L_YEL;
      S_FLASH: begin
        lt1_d = flash_d ? L_OFF : L_YEL;
        lt2_d = flash_d ? L_OFF : L_YEL;
      end
      default: ;
    endcase
  end

  assign lt1      = lt1_q;
  assign lt2      = lt2_q;
  assign phase    = state_q;
  assign sec_left = sec_q;

endmodule
